cam_stream_tx: RTL and testbench

Wishbone-loaded parallel video transmitter that replays a 32-bit word buffer as an 8-bit camera-style stream (PCLKO/VSYNCO/HREFO/DATAO). It is the source end of the FPGA camera capture path: its outputs loop back to, or emulate a sensor for, the PCLKI/VSYNCI/HREFI capture RAM block. It sits on the same AHB-to-FPGA Wishbone slave bus as the capture RAMs. The host fills the buffer, writes a start bit, and the block emits one or more frames.

---
 rtl/cam_stream_tx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cam_stream_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_tx.sv
// cam_stream_tx: Wishbone-loaded transmitter that replays a 32-bit word buffer
// as an 8-bit camera-style stream (PCLKO/VSYNCO/HREFO/DATAO).
// Optional build macro CAM_STREAM_TX_TESTPAT_EN: CTRL bit2 selects a per-frame
// byte-counter test pattern instead of the buffer.
// Assumes V_PORCH >= 1 and H_BLANK >= 1.
module cam_stream_tx #(
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 128,
  parameter int V_PORCH        = 8,
  parameter int H_BLANK        = 16,
  parameter int PCLK_DIV       = 2
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [10:0] WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic        WBs_WE_i,
  input  logic        WBs_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  output logic        PCLKO,
  output logic        VSYNCO,
  output logic        HREFO,
  output logic [7:0]  DATAO
);

  localparam int LINE_SLOTS = 4 * WORDS_PER_LINE;
  localparam int MAX_VH     = (V_PORCH > H_BLANK) ? V_PORCH : H_BLANK;
  localparam int MAX_SLOTS  = (LINE_SLOTS > MAX_VH) ? LINE_SLOTS : MAX_VH;
  localparam int CW         = $clog2(MAX_SLOTS + 1);
  localparam int LW         = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PW         = $clog2(2 * PCLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VLEAD, S_LINE, S_HBLANK, S_VTAIL, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   line_q, line_d;
  logic            frame_done, fetch;
  logic [7:0]      byte_d, pix;
  logic [PW-1:0]   ph_q;
  logic            pclk_q, slot_end;
  logic            vsync_q, href_q;
  logic [7:0]      data_q;
  logic [31:0]     word_q;
  logic [8:0]      faddr_q;
  logic            ack_q, acc, wr, wr_ctrl;
  logic [31:0]     dat_q, rdata, ctrl_rd, status;
  logic            cont_q, start_pend_q;
  logic [15:0]     fcnt_q;
  logic [31:0]     mem [0:511];
  logic            unused_adr;

  assign unused_adr = WBs_ADR_i[9];

  assign acc      = WBs_CYC_i & WBs_STB_i & ~ack_q;
  assign wr       = acc & WBs_WE_i;
  assign wr_ctrl  = wr & WBs_ADR_i[10] & (WBs_ADR_i[1:0] == 2'd0) & WBs_BYTE_STB_i[0];
  assign slot_end = (ph_q == PW'(2 * PCLK_DIV - 1));

  // Free-running slot phase; PCLKO low for the first half-slot, high for the second
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ph_q   <= '0;
      pclk_q <= 1'b0;
    end else if (slot_end) begin
      ph_q   <= '0;
      pclk_q <= 1'b0;
    end else begin
      ph_q   <= ph_q + PW'(1);
      pclk_q <= ((ph_q + PW'(1)) >= PW'(PCLK_DIV));
    end
  end

  // Frame sequencer state register, advanced once per byte slot
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else if (slot_end) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next slot state, prefetch request and byte select for the upcoming slot
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    line_d     = line_q;
    frame_done = 1'b0;
    fetch      = 1'b0;
    byte_d     = 8'h00;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        line_d = '0;
        if (start_pend_q) state_d = S_VLEAD;
      end
      S_VLEAD: begin
        if (cnt_q == CW'(V_PORCH - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt_q == CW'(LINE_SLOTS - 1)) begin
          cnt_d = '0;
          if (line_q == LW'(LINES - 1)) begin
            state_d = S_VTAIL;
          end else begin
            state_d = S_HBLANK;
            line_d  = line_q + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_VTAIL: begin
        if (cnt_q == CW'(V_PORCH - 1)) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = cont_q ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(V_PORCH - 1)) begin
          state_d = S_VLEAD;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Fetch a word one slot ahead of its first byte: the slot before a line,
    // or the last byte slot of a word that is followed by another in the line
    fetch = ((state_d == S_VLEAD)  && (cnt_d == CW'(V_PORCH - 1))) ||
            ((state_d == S_HBLANK) && (cnt_d == CW'(H_BLANK - 1))) ||
            ((state_d == S_LINE)   && (cnt_d[1:0] == 2'b11) &&
             (cnt_d != CW'(LINE_SLOTS - 1)));
    case (cnt_d[1:0])
      2'd0: byte_d = word_q[31:24];
      2'd1: byte_d = word_q[23:16];
      2'd2: byte_d = word_q[15:8];
      2'd3: byte_d = word_q[7:0];
    endcase
  end

`ifdef CAM_STREAM_TX_TESTPAT_EN
  logic       tp_q;
  logic [7:0] tpcnt_q;
  assign pix     = tp_q ? tpcnt_q : byte_d;
  assign ctrl_rd = {29'd0, tp_q, cont_q, 1'b0};

  // Per-frame pattern byte counter, cleared between frames
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      tpcnt_q <= '0;
    end else if (slot_end && (state_d == S_LINE)) begin
      tpcnt_q <= tpcnt_q + 8'd1;
    end else if ((state_q == S_IDLE) || (state_q == S_GAP)) begin
      tpcnt_q <= '0;
    end
  end

  // Test pattern enable register
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) tp_q <= 1'b0;
    else if (wr_ctrl) tp_q <= WBs_DAT_i[2];
  end
`else
  assign pix     = byte_d;
  assign ctrl_rd = {29'd0, 1'b0, cont_q, 1'b0};
`endif

  // Stream outputs change only at slot start (PCLKO fall)
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
    end else if (slot_end) begin
      vsync_q <= (state_d != S_IDLE) && (state_d != S_GAP);
      href_q  <= (state_d == S_LINE);
      data_q  <= (state_d == S_LINE) ? pix : 8'h00;
      if (frame_done) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  // Word prefetch register and sequential buffer pointer
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      word_q  <= '0;
      faddr_q <= '0;
    end else if (slot_end && fetch) begin
      word_q  <= mem[faddr_q];
      faddr_q <= faddr_q + 9'd1;
    end else if ((state_q == S_IDLE) || (state_q == S_GAP)) begin
      faddr_q <= '0;
    end
  end

  // Byte-enabled host writes into the frame buffer
  always_ff @(posedge WBs_CLK_i) begin
    if (wr && !WBs_ADR_i[10]) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (WBs_BYTE_STB_i[i]) mem[WBs_ADR_i[8:0]][8*i +: 8] <= WBs_DAT_i[8*i +: 8];
      end
    end
  end

  // CONT bit and pending START; START is only accepted while idle
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      cont_q       <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      if (wr_ctrl) cont_q <= WBs_DAT_i[1];
      if (slot_end && (state_q == S_IDLE)) start_pend_q <= 1'b0;
      if (wr_ctrl && WBs_DAT_i[0] && (state_q == S_IDLE) && !(slot_end && start_pend_q))
        start_pend_q <= 1'b1;
    end
  end

  assign status = {fcnt_q, 14'd0, href_q, (state_q != S_IDLE)};

  // Read data mux
  always_comb begin
    rdata = '0;
    if (!WBs_ADR_i[10]) begin
      rdata = mem[WBs_ADR_i[8:0]];
    end else begin
      case (WBs_ADR_i[1:0])
        2'd0:    rdata = ctrl_rd;
        2'd1:    rdata = status;
        default: rdata = '0;
      endcase
    end
  end

  // Single-wait-state acknowledge with registered read data
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= acc ? rdata : '0;
    end
  end

  assign WBs_ACK_o = ack_q;
  assign WBs_DAT_o = dat_q;
  assign PCLKO     = pclk_q;
  assign VSYNCO    = vsync_q;
  assign HREFO     = href_q;
  assign DATAO     = data_q;

endmodule

// File: tb/tb_cam_stream_tx.sv
`timescale 1ns/1ps
module tb_cam_stream_tx;
  localparam int LINES = 2, WPL = 2, VP = 2, HB = 3, DIV = 1;
  localparam int FRAME_SLOTS = 2*VP + LINES*4*WPL + (LINES-1)*HB;
  localparam logic [10:0] A_CTRL = 11'h400, A_STAT = 11'h401;

  logic        WBs_CLK_i = 1'b0;
  logic        WBs_RST_i;
  logic [10:0] WBs_ADR_i;
  logic        WBs_CYC_i, WBs_WE_i, WBs_STB_i;
  logic [3:0]  WBs_BYTE_STB_i;
  logic [31:0] WBs_DAT_i, WBs_DAT_o;
  logic        WBs_ACK_o, PCLKO, VSYNCO, HREFO;
  logic [7:0]  DATAO;

  always #5 WBs_CLK_i = ~WBs_CLK_i;

  cam_stream_tx #(.LINES(LINES), .WORDS_PER_LINE(WPL), .V_PORCH(VP),
                  .H_BLANK(HB), .PCLK_DIV(DIV)) dut (
    .WBs_CLK_i(WBs_CLK_i), .WBs_RST_i(WBs_RST_i), .WBs_ADR_i(WBs_ADR_i),
    .WBs_CYC_i(WBs_CYC_i), .WBs_BYTE_STB_i(WBs_BYTE_STB_i), .WBs_WE_i(WBs_WE_i),
    .WBs_STB_i(WBs_STB_i), .WBs_DAT_i(WBs_DAT_i), .WBs_DAT_o(WBs_DAT_o),
    .WBs_ACK_o(WBs_ACK_o), .PCLKO(PCLKO), .VSYNCO(VSYNCO), .HREFO(HREFO),
    .DATAO(DATAO));

  int n_checks = 0, n_pass = 0;
  int exp_fc = 0;
  logic [31:0] buf_m [0:LINES*WPL-1];
  logic [9:0]  exp_q[$];
  logic [9:0]  obs[$];

  // Slot samples {VSYNCO, HREFO, DATAO} taken just after each PCLKO rise
  always @(posedge PCLKO) begin
    #1;
    obs.push_back({VSYNCO, HREFO, DATAO});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wb_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    bit got;
    got = 0;
    @(posedge WBs_CLK_i); #1;
    WBs_ADR_i = a; WBs_DAT_i = d; WBs_BYTE_STB_i = be;
    WBs_WE_i = 1; WBs_CYC_i = 1; WBs_STB_i = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge WBs_CLK_i); #1;
      if (WBs_ACK_o === 1'b1) begin got = 1; break; end
    end
    WBs_CYC_i = 0; WBs_STB_i = 0; WBs_WE_i = 0;
    if (!got) begin
      $display("FAIL wb_write_ack: got no ack, required ack within 8 clocks");
      $fatal(1);
    end
  endtask

  task automatic wb_read(input logic [10:0] a, output logic [31:0] d);
    bit got;
    got = 0; d = 'x;
    @(posedge WBs_CLK_i); #1;
    WBs_ADR_i = a; WBs_BYTE_STB_i = 4'hf; WBs_WE_i = 0; WBs_CYC_i = 1; WBs_STB_i = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge WBs_CLK_i); #1;
      if (WBs_ACK_o === 1'b1) begin got = 1; d = WBs_DAT_o; break; end
    end
    WBs_CYC_i = 0; WBs_STB_i = 0;
    if (!got) begin
      $display("FAIL wb_read_ack: got no ack, required ack within 8 clocks");
      $fatal(1);
    end
  endtask

  task automatic load_buf();
    for (int i = 0; i < LINES*WPL; i++) wb_write(11'(i), buf_m[i], 4'hf);
  endtask

  // Reference frame built from the stream rules: porch, lines of big-endian bytes, blanks, tail
  task automatic build_expected(input bit tp);
    int bc;
    logic [31:0] w;
    logic [7:0] by;
    bc = 0;
    exp_q.delete();
    for (int i = 0; i < VP; i++) exp_q.push_back({2'b10, 8'h00});
    for (int l = 0; l < LINES; l++) begin
      for (int b = 0; b < 4*WPL; b++) begin
        w  = buf_m[l*WPL + b/4];
        by = tp ? bc[7:0] : w[31 - 8*(b%4) -: 8];
        exp_q.push_back({2'b11, by});
        bc++;
      end
      if (l != LINES-1) for (int i = 0; i < HB; i++) exp_q.push_back({2'b10, 8'h00});
    end
    for (int i = 0; i < VP; i++) exp_q.push_back({2'b10, 8'h00});
  endtask

  // Splits the sample log into VSYNC runs; reports frame count, sample errors,
  // idle gap between frames 1 and 2, and the slot length of frame 1
  task automatic scan_obs(output int nfr, output int bad, output int gap, output int flen);
    bit inrun;
    int idx, gcount;
    nfr = 0; bad = 0; gap = -1; flen = 0; inrun = 0; idx = 0; gcount = 0;
    foreach (obs[i]) begin
      if (obs[i][9] === 1'b1) begin
        if (!inrun) begin
          inrun = 1; idx = 0; nfr++;
          if (nfr == 2) gap = gcount;
        end
        if (idx < exp_q.size()) begin
          if (obs[i] !== exp_q[idx]) bad++;
        end else bad++;
        idx++;
        if (nfr == 1) flen = idx;
      end else begin
        if (inrun) begin
          inrun = 0;
          if (idx != exp_q.size()) bad++;
          gcount = 1;
        end else gcount++;
        if (obs[i][8:0] !== 9'd0) bad++;
      end
    end
    if (inrun) bad++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    n_checks++;
    if ({PCLKO, VSYNCO, HREFO, DATAO, WBs_ACK_o, WBs_DAT_o} !== 44'd0)
      $display("FAIL reset_outputs: got %h required 0", {PCLKO, VSYNCO, HREFO, DATAO, WBs_ACK_o, WBs_DAT_o});
    else n_pass++;
    repeat (3) @(posedge WBs_CLK_i);
    #1; WBs_RST_i = 0;
    wb_read(A_STAT, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_status: got %h required 00000000", d); else n_pass++;
    wb_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_ctrl: got %h required 00000000", d); else n_pass++;
  endtask

  task automatic test_frame_fixed();
    int nfr, bad, gap, flen;
    logic [31:0] d;
    buf_m[0] = 32'h11223344; buf_m[1] = 32'h55667788;
    buf_m[2] = 32'h99AABBCC; buf_m[3] = 32'hDDEEFF00;
    load_buf();
    build_expected(0);
    obs.delete();
    wb_write(A_CTRL, 32'h1, 4'h1);
    repeat (FRAME_SLOTS*2*DIV + 30) @(posedge WBs_CLK_i);
    #1;
    scan_obs(nfr, bad, gap, flen);
    exp_fc++;
    n_checks++;
    if (nfr != 1) $display("FAIL fixed_frames: got %0d frames required 1", nfr); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL fixed_samples: got %0d bad slots required 0", bad); else n_pass++;
    n_checks++;
    if (flen != FRAME_SLOTS) $display("FAIL fixed_len: got %0d slots required %0d", flen, FRAME_SLOTS); else n_pass++;
    wb_read(A_STAT, d);
    n_checks++;
    if (d !== {16'(exp_fc), 16'h0000}) $display("FAIL fixed_status: got %h required %h", d, {16'(exp_fc), 16'h0000});
    else n_pass++;
  endtask

  task automatic test_timing();
    int lat, len;
    wb_write(A_CTRL, 32'h1, 4'h1);
    lat = 0;
    while (VSYNCO !== 1'b1 && lat < 10) begin @(posedge WBs_CLK_i); #1; lat++; end
    n_checks++;
    if (lat < 1 || lat > 2*DIV) $display("FAIL start_latency: got %0d clocks required 1..%0d", lat, 2*DIV);
    else n_pass++;
    len = 0;
    while (VSYNCO === 1'b1 && len < 500) begin @(posedge WBs_CLK_i); #1; len++; end
    n_checks++;
    if (len != FRAME_SLOTS*2*DIV) $display("FAIL frame_clocks: got %0d required %0d", len, FRAME_SLOTS*2*DIV);
    else n_pass++;
    exp_fc++;
    repeat (10) @(posedge WBs_CLK_i);
  endtask

  task automatic test_random_frames();
    int nfr, bad, gap, flen;
    logic [31:0] d;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < LINES*WPL; i++) buf_m[i] = $urandom;
      load_buf();
      build_expected(0);
      obs.delete();
      wb_write(A_CTRL, 32'h1, 4'h1);
      repeat (FRAME_SLOTS*2*DIV + 30) @(posedge WBs_CLK_i);
      #1;
      scan_obs(nfr, bad, gap, flen);
      exp_fc++;
      n_checks++;
      if (nfr != 1 || bad != 0) $display("FAIL random_frame%0d: got %0d frames %0d bad slots required 1 frame 0 bad", it, nfr, bad);
      else n_pass++;
    end
    wb_read(A_STAT, d);
    n_checks++;
    if (d[31:16] !== 16'(exp_fc)) $display("FAIL random_frame_cnt: got %0d required %0d", d[31:16], exp_fc);
    else n_pass++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    wb_write(11'd5, 32'hFFFFFFFF, 4'hf);
    wb_write(11'd5, 32'h00000000, 4'b0101);
    wb_read(11'd5, d);
    n_checks++;
    if (d !== 32'hFF00FF00) $display("FAIL byte_enable: got %h required FF00FF00", d); else n_pass++;
  endtask

  task automatic test_busy_start();
    int nfr, bad, gap, flen;
    logic [31:0] d;
    build_expected(0);
    obs.delete();
    wb_write(A_CTRL, 32'h1, 4'h1);
    repeat (16) @(posedge WBs_CLK_i);
    wb_read(A_STAT, d);
    n_checks++;
    if (d[0] !== 1'b1 || d[31:16] !== 16'(exp_fc))
      $display("FAIL busy_status: got busy=%b cnt=%0d required busy=1 cnt=%0d", d[0], d[31:16], exp_fc);
    else n_pass++;
    wb_write(A_CTRL, 32'h1, 4'h1);
    repeat (FRAME_SLOTS*2*DIV + 30) @(posedge WBs_CLK_i);
    #1;
    scan_obs(nfr, bad, gap, flen);
    exp_fc++;
    n_checks++;
    if (nfr != 1) $display("FAIL busy_frames: got %0d frames required 1", nfr); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL busy_samples: got %0d bad slots required 0", bad); else n_pass++;
    n_checks++;
    if (flen != FRAME_SLOTS) $display("FAIL busy_len: got %0d slots required %0d", flen, FRAME_SLOTS); else n_pass++;
  endtask

  task automatic test_host_write_busy();
    int nfr, bad, gap, flen, k;
    logic [31:0] n0, n3;
    n0 = $urandom; n3 = $urandom;
    buf_m[3] = n3;          // not yet fetched when written: new value appears
    build_expected(0);      // word 0 is already fetched: old value expected
    obs.delete();
    wb_write(A_CTRL, 32'h1, 4'h1);
    k = 0;
    while (HREFO !== 1'b1 && k < 100) begin @(posedge WBs_CLK_i); #1; k++; end
    n_checks++;
    if (HREFO !== 1'b1) $display("FAIL hw_href_wait: got HREFO=%b required 1 within 100 clocks", HREFO); else n_pass++;
    repeat (10) @(posedge WBs_CLK_i);
    wb_write(11'd0, n0, 4'hf);
    wb_write(11'd3, n3, 4'hf);
    buf_m[0] = n0;
    repeat (FRAME_SLOTS*2*DIV + 30) @(posedge WBs_CLK_i);
    #1;
    scan_obs(nfr, bad, gap, flen);
    exp_fc++;
    n_checks++;
    if (nfr != 1 || bad != 0) $display("FAIL host_write_busy: got %0d frames %0d bad slots required 1 frame 0 bad", nfr, bad);
    else n_pass++;
  endtask

  task automatic test_cont();
    int nfr, bad, gap, flen, k;
    logic [31:0] d;
    build_expected(0);
    obs.delete();
    wb_write(A_CTRL, 32'h3, 4'h1);
    k = 0;
    while (VSYNCO !== 1'b1 && k < 20) begin @(posedge WBs_CLK_i); #1; k++; end
    while (VSYNCO !== 1'b0 && k < 200) begin @(posedge WBs_CLK_i); #1; k++; end
    while (VSYNCO !== 1'b1 && k < 260) begin @(posedge WBs_CLK_i); #1; k++; end
    n_checks++;
    if (VSYNCO !== 1'b1) $display("FAIL cont_restart: got VSYNCO=%b required 1 within 260 clocks", VSYNCO); else n_pass++;
    wb_write(A_CTRL, 32'h0, 4'h1);
    repeat (3*FRAME_SLOTS*2*DIV) @(posedge WBs_CLK_i);
    #1;
    scan_obs(nfr, bad, gap, flen);
    exp_fc += 2;
    n_checks++;
    if (nfr != 2) $display("FAIL cont_frames: got %0d frames required 2", nfr); else n_pass++;
    n_checks++;
    if (gap != VP) $display("FAIL cont_gap: got %0d slots required %0d", gap, VP); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL cont_samples: got %0d bad slots required 0", bad); else n_pass++;
    wb_read(A_STAT, d);
    n_checks++;
    if (d !== {16'(exp_fc), 16'h0000}) $display("FAIL cont_status: got %h required %h", d, {16'(exp_fc), 16'h0000});
    else n_pass++;
  endtask

  task automatic test_testpat();
    logic [31:0] d;
`ifdef CAM_STREAM_TX_TESTPAT_EN
    int nfr, bad, gap, flen;
    build_expected(1);
    obs.delete();
    wb_write(A_CTRL, 32'h5, 4'h1);
    repeat (FRAME_SLOTS*2*DIV + 30) @(posedge WBs_CLK_i);
    #1;
    scan_obs(nfr, bad, gap, flen);
    exp_fc++;
    n_checks++;
    if (nfr != 1 || bad != 0) $display("FAIL testpat_frame: got %0d frames %0d bad slots required 1 frame 0 bad", nfr, bad);
    else n_pass++;
    wb_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h4) $display("FAIL testpat_ctrl: got %h required 00000004", d); else n_pass++;
    wb_write(A_CTRL, 32'h0, 4'h1);
`else
    wb_write(A_CTRL, 32'h4, 4'h1);
    wb_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL ctrl_bit2_absent: got %h required 00000000", d); else n_pass++;
    wb_write(A_CTRL, 32'h0, 4'h1);
`endif
  endtask

  task automatic test_reset_mid();
    int k, tog;
    logic prev;
    logic [31:0] d;
    wb_write(A_CTRL, 32'h1, 4'h1);
    k = 0;
    while (HREFO !== 1'b1 && k < 100) begin @(posedge WBs_CLK_i); #1; k++; end
    #2; WBs_RST_i = 1;
    #1;
    n_checks++;
    if ({k < 100, PCLKO, VSYNCO, HREFO, DATAO} !== {1'b1, 11'd0})
      $display("FAIL reset_mid_line: got href_seen=%0d outputs=%h required 1 and 000", k < 100, {PCLKO, VSYNCO, HREFO, DATAO});
    else n_pass++;
    repeat (2) @(posedge WBs_CLK_i);
    #1; WBs_RST_i = 0;
    prev = PCLKO; tog = 0;
    repeat (10) begin
      @(posedge WBs_CLK_i); #1;
      if (PCLKO !== prev) tog++;
      prev = PCLKO;
    end
    n_checks++;
    if (tog != 10/DIV) $display("FAIL reset_pclk_toggle: got %0d toggles required %0d", tog, 10/DIV); else n_pass++;
    wb_read(A_STAT, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_mid_status: got %h required 00000000", d); else n_pass++;
  endtask

  initial begin
    WBs_RST_i = 1; WBs_ADR_i = '0; WBs_CYC_i = 0; WBs_STB_i = 0; WBs_WE_i = 0;
    WBs_BYTE_STB_i = '0; WBs_DAT_i = '0;
    test_reset();
    test_frame_fixed();
    test_timing();
    test_random_frames();
    test_byte_enable();
    test_busy_start();
    test_host_write_busy();
    test_cont();
    test_testpat();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
